// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-input mux: registered one-hot grant, mux select and busy,
// with a bounded hold time so a continuously requesting owner cannot starve the others.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [1:0]       last_r, last_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [3:0]       grant_s;
    logic [1:0]       sel_s;
    logic             busy_s;
    logic [3:0]       owner_mask_s;
    logic [3:0]       others_s;
    logic             owner_req_s;
    logic [2:0]       pick_idle_s;
    logic [2:0]       pick_rot_s;

    // Returns {found, index} of the first set bit of mask searching base+1, base+2, base+3, base.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign owner_mask_s = 4'b0001 << sel;
    assign others_s     = req & ~owner_mask_s;
    assign owner_req_s  = |(req & owner_mask_s);
    assign pick_idle_s  = rr_pick(req, last_r);
    assign pick_rot_s   = rr_pick(others_s, sel);

    // Next-state and next-output decision; the owner is always the current sel value.
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        hold_cnt_s = hold_cnt_r;
        grant_s    = grant;
        sel_s      = sel;
        busy_s     = busy;
        case (state_r)
            IDLE: begin
                if (pick_idle_s[2]) begin
                    state_s    = GRANT;
                    grant_s    = 4'b0001 << pick_idle_s[1:0];
                    sel_s      = pick_idle_s[1:0];
                    busy_s     = 1'b1;
                    hold_cnt_s = HOLD_ONE_C;
                end else begin
                    grant_s = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req_s || ((hold_cnt_r == HOLD_MAX_C) && pick_rot_s[2])) begin
                    // Owner released or used up its hold budget under contention.
                    last_s = sel;
                    if (pick_rot_s[2]) begin
                        grant_s    = 4'b0001 << pick_rot_s[1:0];
                        sel_s      = pick_rot_s[1:0];
                        busy_s     = 1'b1;
                        hold_cnt_s = HOLD_ONE_C;
                    end else begin
                        state_s = IDLE;
                        grant_s = 4'b0000;
                        busy_s  = 1'b0;
                    end
                end else if (hold_cnt_r == HOLD_MAX_C) begin
                    hold_cnt_s = HOLD_MAX_C;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE_C;
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = 4'b0000;
                busy_s     = 1'b0;
                hold_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= 2'd3;
            hold_cnt_r <= {CNT_W{1'b0}};
            grant      <= 4'b0000;
            sel        <= 2'b00;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            hold_cnt_r <= hold_cnt_s;
            grant      <= grant_s;
            sel        <= sel_s;
            busy       <= busy_s;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD 4 and 1) run against a behavioural
// round-robin model under directed scenarios followed by random request traffic.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant_a, grant_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fails  = 0;

    int m_owner[2];
    int m_busy[2];
    int m_hold[2];
    int m_last[2];
    int m_sel[2];
    int m_max[2] = '{4, 1};

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .grant(grant_a), .sel(sel_a), .busy(busy_a)
    );

    mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .grant(grant_b), .sel(sel_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester set in m, searching base+1, base+2, base+3, base; -1 if none.
    function automatic int rr_next(input logic [3:0] m, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (m[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 0;
            m_busy[i]  = 0;
            m_hold[i]  = 0;
            m_last[i]  = 3;
            m_sel[i]   = 0;
        end
    endtask

    task automatic model_step(input int i, input logic [3:0] r);
        int p;
        int own;
        logic [3:0] oth;
        if (m_busy[i] == 0) begin
            p = rr_next(r, m_last[i]);
            if (p >= 0) begin
                m_busy[i]  = 1;
                m_owner[i] = p;
                m_sel[i]   = p;
                m_hold[i]  = 1;
            end
        end else begin
            own      = m_owner[i];
            oth      = r;
            oth[own] = 1'b0;
            if (!r[own] || (m_hold[i] == m_max[i] && oth != 4'b0000)) begin
                m_last[i] = own;
                p = rr_next(oth, own);
                if (p >= 0) begin
                    m_owner[i] = p;
                    m_sel[i]   = p;
                    m_hold[i]  = 1;
                end else begin
                    m_busy[i] = 0;
                end
            end else if (m_hold[i] < m_max[i]) begin
                m_hold[i]++;
            end
        end
    endtask

    task automatic compare_inst(input int i, input logic [3:0] g, input logic [1:0] s, input logic b);
        logic [3:0] exp_g;
        exp_g = (m_busy[i] != 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        check_eq($sformatf("grant[%0d]", i), int'(g), int'(exp_g));
        check_eq($sformatf("sel[%0d]", i), int'(s), m_sel[i]);
        check_eq($sformatf("busy[%0d]", i), int'(b), m_busy[i]);
        check_eq($sformatf("onehot[%0d]", i), int'($countones(g) <= 1), 1);
        check_eq($sformatf("grant_sel[%0d]", i), int'(g[s]), int'(b));
    endtask

    task automatic compare_all();
        compare_inst(0, grant_a, sel_a, busy_a);
        compare_inst(1, grant_b, sel_b, busy_b);
    endtask

    // Drives r for n cycles; called and returning at a falling edge.
    task automatic run(input logic [3:0] r, input int n);
        for (int c = 0; c < n; c++) begin
            req = r;
            @(posedge clk);
            model_step(0, r);
            model_step(1, r);
            @(negedge clk);
            compare_all();
        end
    endtask

    // Asserts reset away from any clock edge and checks outputs clear before the next edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        run(4'b0000, 5);
        run(4'b1111, 20);
        run(4'b0000, 1);
        run(4'b0100, 10);
        run(4'b0000, 2);

        async_reset();
        run(4'b0010, 2);
        run(4'b1001, 2);
        run(4'b0001, 2);
        run(4'b0000, 1);

        run(4'b0100, 2);
        async_reset();
        run(4'b1100, 2);
        run(4'b0000, 1);

        async_reset();
        run(4'b0011, 6);

        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) async_reset();
            run(r, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4-input `mux4` datapath between four requesters.
- Drives the mux `sel[1:0]` and a one-hot grant vector. Requester n owns mux input dn.
- A grant is held while its requester keeps `req` asserted, up to `MAX_HOLD` cycles under contention. After that it is forcibly rotated, so no requester starves.
- Sits directly in front of `mux4`: `sel` connects to `mux4.sel`, and `grant[n]` tells requester n that its data is on `z`.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester may keep the grant while another request is pending; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector, bit n = requester n; level-sensitive.
- grant  output  4  registered one-hot grant, or all zeros when idle.
- sel  output  2  registered mux select; equals the index of the granted requester.
- busy  output  1  registered; 1 when any grant bit is set.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- All outputs and state are registered. There are no combinational paths from `req` to outputs.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - grant=4'b0000, sel=2'b00, busy=0.
  - state=IDLE, hold_cnt=0, last=2'd3, so requester 0 has top priority after reset.
- Priority order: search starts at (last+1) mod 4 and wraps: last+1, last+2, last+3, last.
- State IDLE:
  - req==0: stay IDLE; grant=0; sel holds its previous value.
  - req!=0: next edge, grant the first set bit in priority order, sel=its index, busy=1, hold_cnt=1, go to GRANT.
  - Latency from req to grant is 1 cycle.
- State GRANT (owner = sel). Evaluated each edge, first match wins:
  1. req[owner]==0, others pending: last=owner; next edge grant moves to the next requester in priority order; hold_cnt=1. No idle bubble.
  2. req[owner]==0, none pending: last=owner; grant=0, busy=0, go to IDLE. sel keeps the owner value.
  3. req[owner]==1, hold_cnt==MAX_HOLD, another req pending: forced rotation. last=owner; grant to the next pending requester in priority order, excluding owner; hold_cnt=1.
  4. req[owner]==1, hold_cnt==MAX_HOLD, no other req: keep grant; hold_cnt saturates at MAX_HOLD.
  5. Otherwise: keep grant; hold_cnt=hold_cnt+1.
- Invariants:
  - grant is always one-hot or zero.
  - When busy=1, grant[sel]==1.
  - busy == |grant.
- Other requests arriving during a grant never preempt the owner before MAX_HOLD.
- With MAX_HOLD=1 and continuous contention, the grant rotates every cycle.
- Simultaneous requests resolve purely by round-robin order. There is no fixed priority except immediately after reset.
- Unknown or X on req is not supported; the bench drives only 0/1.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, busy=0, sel=0 throughout.
- After reset, req=4'b1111 held, MAX_HOLD=4 -> grant=0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then wraps to 0001; sel follows 0,1,2,3,0.
- req=4'b0100 alone for 10 cycles -> grant=0100 from cycle 1, sel=2, held all 10 cycles (saturation, case 4). Drop req -> grant=0 next edge, sel stays 2.
- Owner 1 granted, drop req[1] while req=4'b1001 -> next edge grant=1000 (sel=3), with no idle cycle. Drop req[3] -> grant=0001.
- During a grant to requester 2, assert rst asynchronously mid-cycle -> grant=0, busy=0, sel=0 immediately, before the next edge. Release with req=4'b1100 -> grant=0100 (last=3 resets priority to 0,1,2,...).
- MAX_HOLD=1, req=4'b0011 held -> grant alternates 0001, 0010, 0001, ... every cycle.
- All scenarios check the invariants every cycle: grant one-hot or zero, and grant[sel]==busy.
